// File: rtl/synth_pkg.sv
// Shared types and constants for the synth_core envelope/note sequencer.
package synth_pkg;

  localparam int VOL_W              = 5;
  localparam int FMULT_W            = 16;
  localparam int SAMPLE_DIV_DEFAULT = 1247;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Smaller of two volume levels; sustain can never sit above the note peak.
  function automatic logic [VOL_W-1:0] vol_min(input logic [VOL_W-1:0] a,
                                               input logic [VOL_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/synth_env_ctrl_if.sv
// Note command handshake between the sequencer (master) and synth_env_ctrl (slave).
interface synth_env_ctrl_if;
  import synth_pkg::*;

  logic               note_valid;
  logic               note_ready;
  logic               note_on;
  logic [FMULT_W-1:0] note_f_mult;
  logic [VOL_W-1:0]   note_vel;

  modport master (
    output note_valid, note_on, note_f_mult, note_vel,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_on, note_f_mult, note_vel,
    output note_ready
  );

endinterface

// File: rtl/synth_tick_gen.sv
// Sample-rate tick generator: counter runs 0..SAMPLE_DIV and wraps;
// sample_tick is registered so it is high exactly while the counter equals SAMPLE_DIV.
module synth_tick_gen #(
  parameter int SAMPLE_DIV = 1247
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_tick
);

  localparam int CNT_W = (SAMPLE_DIV < 1) ? 1 : $clog2(SAMPLE_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next counter value with wrap at SAMPLE_DIV.
  always_comb begin
    cnt_nxt = (cnt == DIV_C) ? '0 : cnt + CNT_W'(1);
  end

  // Counter and tick register; the tick is decoded from the next count so it
  // lines up with the cycle in which the counter holds SAMPLE_DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      sample_tick <= (cnt_nxt == DIV_C);
    end
  end

endmodule

// File: rtl/synth_env_ctrl.sv
// ADSR envelope and note sequencer driving synth_core vol/f_mult.
// All output changes land on sample-tick boundaries. Optional build macro:
//   SYNTH_ENV_LEGATO_EN - note on during ATTACK/DECAY/SUSTAIN only retunes
//                         f_mult and peak instead of retriggering the attack.
//
// state   | meaning
// IDLE    | silent, vol forced to 0, f_mult held
// ATTACK  | vol ramps up towards peak
// DECAY   | vol ramps down towards min(sustain_lvl, peak)
// SUSTAIN | vol held until the next command
// RELEASE | vol ramps down to 0, then IDLE
module synth_env_ctrl
  import synth_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
  parameter int RATE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  synth_env_ctrl_if.slave    note_if,
  input  logic [RATE_W-1:0]  attack_rate,
  input  logic [RATE_W-1:0]  decay_rate,
  input  logic [RATE_W-1:0]  release_rate,
  input  logic [VOL_W-1:0]   sustain_lvl,
  output logic [FMULT_W-1:0] f_mult,
  output logic [VOL_W-1:0]   vol,
  output logic               active,
  output logic               sample_tick
);

  env_state_t         state, state_nxt;
  logic [VOL_W-1:0]   vol_nxt;
  logic [FMULT_W-1:0] f_mult_nxt;
  logic [VOL_W-1:0]   peak, peak_nxt;
  logic [RATE_W-1:0]  step_cnt, step_cnt_nxt;

  logic               pend_valid, pend_valid_nxt;
  logic               pend_on, pend_on_nxt;
  logic [FMULT_W-1:0] pend_f_mult, pend_f_mult_nxt;
  logic [VOL_W-1:0]   pend_vel, pend_vel_nxt;

  logic [RATE_W-1:0]  cur_rate;
  logic [VOL_W-1:0]   target;
  logic               cmd_fire;
  logic               step_en;
  logic               cmd_is_on;

  synth_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick)
  );

  assign note_if.note_ready = !pend_valid;
  assign active             = (state != IDLE);
  assign cmd_fire           = note_if.note_valid && !pend_valid;
  assign target             = vol_min(sustain_lvl, peak);
  assign cmd_is_on          = pend_on && (pend_vel != '0);

  // Rate of the current state; IDLE and SUSTAIN never move vol, so any rate works.
  always_comb begin
    cur_rate = '0;
    case (state)
      ATTACK:  cur_rate = attack_rate;
      DECAY:   cur_rate = decay_rate;
      RELEASE: cur_rate = release_rate;
      default: cur_rate = '0;
    endcase
  end

  // State, envelope, pending-command and step-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vol         <= '0;
      f_mult      <= '0;
      peak        <= '0;
      step_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_on     <= 1'b0;
      pend_f_mult <= '0;
      pend_vel    <= '0;
    end else begin
      state       <= state_nxt;
      vol         <= vol_nxt;
      f_mult      <= f_mult_nxt;
      peak        <= peak_nxt;
      step_cnt    <= step_cnt_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_on     <= pend_on_nxt;
      pend_f_mult <= pend_f_mult_nxt;
      pend_vel    <= pend_vel_nxt;
    end
  end

  // Command capture, then per-tick command apply or envelope step.
  always_comb begin
    state_nxt       = state;
    vol_nxt         = vol;
    f_mult_nxt      = f_mult;
    peak_nxt        = peak;
    step_cnt_nxt    = step_cnt;
    pend_valid_nxt  = pend_valid;
    pend_on_nxt     = pend_on;
    pend_f_mult_nxt = pend_f_mult;
    pend_vel_nxt    = pend_vel;
    step_en         = 1'b0;

    // Slot is free only when nothing is pending, so capture and apply never collide.
    if (cmd_fire) begin
      pend_valid_nxt  = 1'b1;
      pend_on_nxt     = note_if.note_on;
      pend_f_mult_nxt = note_if.note_f_mult;
      pend_vel_nxt    = note_if.note_vel;
    end

    if (sample_tick) begin
      if (pend_valid) begin
        // A command tick never also steps the envelope.
        pend_valid_nxt = 1'b0;
        step_cnt_nxt   = '0;
        if (cmd_is_on) begin
          f_mult_nxt = pend_f_mult;
          peak_nxt   = pend_vel;
`ifdef SYNTH_ENV_LEGATO_EN
          if (state == IDLE || state == RELEASE) state_nxt = ATTACK;
`else
          state_nxt = ATTACK;
`endif
        end else if (state == ATTACK || state == DECAY || state == SUSTAIN) begin
          state_nxt = RELEASE;
        end
      end else begin
        if (step_cnt >= cur_rate) begin
          step_en      = 1'b1;
          step_cnt_nxt = '0;
        end else begin
          step_cnt_nxt = step_cnt + RATE_W'(1);
        end
      end
    end

    if (step_en) begin
      case (state)
        IDLE: vol_nxt = '0;
        ATTACK: begin
          if (vol < peak) vol_nxt = vol + VOL_W'(1);
          else            state_nxt = DECAY;
        end
        DECAY: begin
          if (vol > target) vol_nxt = vol - VOL_W'(1);
          else              state_nxt = SUSTAIN;
        end
        SUSTAIN: vol_nxt = vol;
        RELEASE: begin
          if (vol != '0) vol_nxt = vol - VOL_W'(1);
          else           state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/synth_env_ctrl.md
# synth_env_ctrl

Envelope and note sequencer for the `synth_core` sine voice. It accepts note-on/note-off commands over a valid/ready handshake and drives the core's `vol` (5-bit) and `f_mult` (16-bit) inputs through an ADSR state machine. All output updates happen on sample-tick boundaries, so the core never sees a mid-sample change. It sits between the control/sequencer logic and `synth_core`, in the same 60 MHz clock domain.

## Interface
- `SAMPLE_DIV`, 1247: sample tick period is `SAMPLE_DIV+1` clocks (1248 gives about 48 kHz at 60 MHz).
- `RATE_W`, 8: width of the rate inputs.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `note_valid`  in  1  command valid.
- `note_ready`  out  1  command slot free.
- `note_on`  in  1  1 = note on, 0 = note off.
- `note_f_mult`  in  16  phase increment for note on.
- `note_vel`  in  5  peak volume for note on.
- `attack_rate`  in  RATE_W  extra ticks per attack step.
- `decay_rate`  in  RATE_W  extra ticks per decay step.
- `release_rate`  in  RATE_W  extra ticks per release step.
- `sustain_lvl`  in  5  sustain volume.
- `f_mult`  out  16  to `synth_core.f_mult`.
- `vol`  out  5  to `synth_core.vol`.
- `active`  out  1  high when the state is not IDLE.
- `sample_tick`  out  1  one-cycle pulse when the tick counter equals `SAMPLE_DIV`.

## Operation
**Command capture**
- The handshake completes on `note_valid && note_ready`.
- The command (`note_on`, `note_f_mult`, `note_vel`) is latched into a one-entry pending register, and `note_ready` drops.

**Tick processing.** On each tick:
- If a command is pending, apply it, clear pending, reset the step counter, and take no envelope step this tick.
- Otherwise the step counter increments. When it equals the current state's rate, take a step and reset the counter. Rate 0 means a step every tick.
- Rate inputs are sampled live. The sustain target is `min(sustain_lvl, peak)`.

**Applying a command**
- Note on with `note_vel==0` is treated as note off.
- Note on: set `f_mult`, set peak to `note_vel`, go to ATTACK. `vol` keeps its current value, so there is no click.
- Note off: from ATTACK, DECAY or SUSTAIN go to RELEASE. In IDLE or RELEASE it has no effect.

**States**
- IDLE: `vol`=0, `f_mult` held.
- ATTACK: on a step, if `vol`<peak, `vol`+1; otherwise go to DECAY. A retrigger with `vol`>peak therefore decays down to peak via DECAY.
- DECAY: on a step, if `vol`>target, `vol`-1; otherwise go to SUSTAIN.
- SUSTAIN: hold `vol` until a command arrives.
- RELEASE: on a step, if `vol`>0, `vol`-1. When `vol` is 0, go to IDLE on that same step.

## Timing
- Reset values: `note_ready`=1, `vol`=0, `f_mult`=0, `active`=0, `sample_tick`=0. State is IDLE, all counters are 0, and pending is empty. Reset asserted mid-envelope clears everything immediately.
- The tick counter runs 0..`SAMPLE_DIV` and wraps. `sample_tick` is registered and is high during the cycle in which the counter equals `SAMPLE_DIV`.
- Processing happens at the clock edge that ends the tick cycle:
  - new `vol`, `f_mult` and `active` are visible from the next cycle;
  - `note_ready` returns to 1 at that same edge.
- A handshake in the tick cycle itself is stored and applied at the following tick.
- Command-to-output latency is at most `SAMPLE_DIV+2` clocks.
- `vol` never wraps: increments saturate at peak and decrements stop at 0.

## Configuration
- `SYNTH_ENV_LEGATO_EN` defined: a note on arriving in ATTACK, DECAY or SUSTAIN updates only `f_mult` and peak. State and `vol` are unchanged, except that the DECAY/SUSTAIN target is recomputed. Note on from RELEASE or IDLE still goes to ATTACK.
- Not defined: every note on retriggers to ATTACK as described in Operation.

## Structure
- Package `synth_pkg` holds:
  - `env_state_t` enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE);
  - `VOL_W`=5, `FMULT_W`=16;
  - `SAMPLE_DIV_DEFAULT`=1247.
- Sub-module `synth_tick_gen` (parameter `SAMPLE_DIV`) contains the tick counter and the `sample_tick` register. The state machine, step counter and pending register live in the top.

## Test plan
Bench uses `SAMPLE_DIV`=3, so a tick occurs every 4 clocks.
- Reset: pulse `rst_n` low mid-RELEASE with `vol`=6 -> all outputs return to reset values immediately; `note_ready`=1.
- Attack and decay: note on with f=0x1234, vel 16, sustain 8, all rates 0 -> at the apply tick `f_mult`=0x1234 and `vol`=0. `vol` then rises 1 per tick to 16, falls to 8, and the state is SUSTAIN.
- Attack rate: `attack_rate`=2 -> `vol` increments once every 3 ticks.
- Release: note off in SUSTAIN at `vol`=8, release 0 -> `vol` reaches 0 after 8 ticks; `active` falls on the tick that finds `vol`=0.
- Handshake: two back-to-back valid commands -> `note_ready` stays low after the first until its apply tick; the second is accepted afterwards and applied one tick later.
- Retrigger and clamp:
  - note on vel 10 during RELEASE at `vol`=5 -> `vol` rises 5 to 10;
  - sustain 20 -> `vol` holds at 10;
  - with `SYNTH_ENV_LEGATO_EN`, a note on f=0x0800 in SUSTAIN changes only `f_mult`.
